fetch_dreg: RTL and testbench

FETCH_DREG -- requirements
Module: fetch_dreg

---
 rtl/fetch_dreg.sv | 107 ++++++++++
 tb/tb_fetch_dreg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_dreg.sv
// fetch_dreg: IF stage PC register plus the IF/D pipeline register.
// Computes the next PC from sequential, beq, j/jal and jr sources; the
// instruction fetched behind a branch/jump (delay slot) is never flushed.
// Optional stalled-cycle counter enabled by defining FETCH_STALL_CNT_EN;
// without it stall_cnt is tied to zero and no counter flops exist.
module fetch_dreg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_eq,
  input  logic [31:0] rs_val,
  input  logic [31:0] im_data,
  output logic [31:0] im_addr,
  output logic [31:0] ir_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc8_d,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BEQ = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic [31:0] pc_f_q,  pc_f_d;
  logic [31:0] ir_d_q,  ir_d_d;
  logic [31:0] pc4_d_q, pc4_d_d;
  logic [31:0] pc4_f;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] next_pc;

  // Redirect targets derived from the D-stage instruction
  always_comb begin
    pc4_f     = pc_f_q + 32'd4;
    br_target = pc4_d_q + {{14{ir_d_q[15]}}, ir_d_q[15:0], 2'b00};
    j_target  = {pc4_d_q[31:28], ir_d_q[25:0], 2'b00};
  end

  // Next-PC selection
  always_comb begin
    next_pc = pc4_f;
    unique case (npc_sel_e'(npc_sel))
      NPC_SEQ: next_pc = pc4_f;
      NPC_BEQ: next_pc = br_eq ? br_target : pc4_f;
      NPC_J:   next_pc = j_target;
      NPC_JR:  next_pc = rs_val;
      default: next_pc = pc4_f;
    endcase
  end

  // Pipeline register next-state: stall holds everything, including a pending redirect
  always_comb begin
    pc_f_d  = pc_f_q;
    ir_d_d  = ir_d_q;
    pc4_d_d = pc4_d_q;
    if (!stall) begin
      pc_f_d  = next_pc;
      ir_d_d  = im_data;
      pc4_d_d = pc4_f;
    end
  end

  // PC and IF/D register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f_q  <= PC_RESET;
      ir_d_q  <= '0;
      pc4_d_q <= PC_RESET;
    end else begin
      pc_f_q  <= pc_f_d;
      ir_d_q  <= ir_d_d;
      pc4_d_q <= pc4_d_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled edges
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign im_addr = pc_f_q;
  assign ir_d    = ir_d_q;
  assign pc4_d   = pc4_d_q;
  assign pc8_d   = pc4_d_q + 32'd4;

endmodule

// File: tb/tb_fetch_dreg.sv
// Testbench for fetch_dreg: directed scenarios followed by random stimulus,
// all checked against a behavioural model of the fetch/decode rules.
module tb_fetch_dreg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_eq;
  logic [31:0] rs_val;
  logic [31:0] im_data;
  logic [31:0] im_addr;
  logic [31:0] ir_d;
  logic [31:0] pc4_d;
  logic [31:0] pc8_d;
  logic [31:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ir, m_pc4, m_cnt;

  fetch_dreg dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .br_eq    (br_eq),
    .rs_val   (rs_val),
    .im_data  (im_data),
    .im_addr  (im_addr),
    .ir_d     (ir_d),
    .pc4_d    (pc4_d),
    .pc8_d    (pc8_d),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".im_addr"},   im_addr,   m_pc);
    chk({tag, ".ir_d"},      ir_d,      m_ir);
    chk({tag, ".pc4_d"},     pc4_d,     m_pc4);
    chk({tag, ".pc8_d"},     pc8_d,     m_pc4 + 32'd4);
    chk({tag, ".stall_cnt"}, stall_cnt, m_cnt);
  endtask

  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic eq,
                                             input logic [31:0] rs);
    int signed off;
    off = int'(signed'(m_ir[15:0])) * 4;
    case (sel)
      2'd1:    return eq ? m_pc4 + 32'(off) : m_pc + 32'd4;
      2'd2:    return (m_pc4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
      2'd3:    return rs;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  // One clock edge with the given inputs; inputs change just after the previous edge
  task automatic step(input logic st, input logic [1:0] sel, input logic eq,
                      input logic [31:0] rs, input logic [31:0] im, input string tag);
    logic [31:0] nxt;
    stall = st; npc_sel = sel; br_eq = eq; rs_val = rs; im_data = im;
    @(posedge clk);
    if (st) begin
`ifdef FETCH_STALL_CNT_EN
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    end else begin
      nxt   = model_next(sel, eq, rs);
      m_pc4 = m_pc + 32'd4;
      m_ir  = im;
      m_pc  = nxt;
    end
    #1;
    chk_all(tag);
  endtask

  // Reset pulse placed between edges; reset values must appear immediately
  task automatic pulse_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    m_pc = 32'h0000_3000; m_ir = '0; m_pc4 = 32'h0000_3000; m_cnt = '0;
    chk_all(tag);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; npc_sel = 2'd0; br_eq = 1'b0; rs_val = '0; im_data = '0;
    m_pc = 32'h0000_3000; m_ir = '0; m_pc4 = 32'h0000_3000; m_cnt = '0;
    #12;
    chk_all("reset");
    chk("reset.im_addr_const", im_addr, 32'h0000_3000);
    chk("reset.pc8_const",     pc8_d,   32'h0000_3004);
    @(negedge clk);
    reset = 1'b1;

    // First fetch after reset
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h3C01_0001, "seq1");
    chk("seq1.ir_const", ir_d, 32'h3C01_0001);
    chk("seq1.pc_const", im_addr, 32'h0000_3004);

    // beq taken, with another beq in its delay slot, then beq not taken
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h1022_0003, "beq_load");
    chk("beq_load.pc4_const", pc4_d, 32'h0000_3008);
    step(1'b0, 2'd1, 1'b1, 32'h0, 32'h1022_0003, "beq_taken");
    chk("beq_taken.pc_const", im_addr, 32'h0000_3014);
    step(1'b0, 2'd1, 1'b0, 32'h0, 32'h0000_0000, "beq_not_taken");
    chk("beq_not_taken.pc_const", im_addr, 32'h0000_3018);

    // jal straight after reset
    pulse_reset("rst_jal");
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0C00_0C10, "jal_load");
    chk("jal_load.pc8_const", pc8_d, 32'h0000_3008);
    step(1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_0000, "jal");
    chk("jal.pc_const", im_addr, 32'h0000_3040);

    // Stall dominates a pending jr for 3 edges
    pulse_reset("rst_stall");
    for (int unsigned i = 0; i < 3; i++)
      step(1'b1, 2'd3, 1'b0, 32'h0000_3100, $urandom, "stall_jr");
`ifdef FETCH_STALL_CNT_EN
    chk("stall3.cnt_const", stall_cnt, 32'd3);
`else
    chk("stall3.cnt_const", stall_cnt, 32'd0);
`endif
    step(1'b0, 2'd3, 1'b0, 32'h0000_3100, 32'h0000_0000, "jr_release");
    chk("jr_release.pc_const", im_addr, 32'h0000_3100);

    // Reset mid-stall discards the stall and the pending redirect
    step(1'b1, 2'd3, 1'b0, 32'h0000_5000, 32'h1234_5678, "pre_rst_stall");
    stall = 1'b1; npc_sel = 2'd3; rs_val = 32'h0000_5000;
    pulse_reset("rst_midstall");
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'hABCD_0001, "after_rst");
    chk("after_rst.pc4_const", pc4_d, 32'h0000_3004);

    // Random traffic with occasional resets
    for (int unsigned i = 0; i < 200; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom, $urandom, "rnd");
    end

    // Wrap of the sequential PC past the top of the address space
    step(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFC, 32'h0, "to_top");
    chk("to_top.pc_const", im_addr, 32'hFFFF_FFFC);
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, "wrap");
    chk("wrap.pc_const", im_addr, 32'h0000_0000);

`ifdef FETCH_STALL_CNT_EN
    // Counter saturation from a preloaded all-ones value
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, "sat1");
    step(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, "sat2");
    chk("sat.cnt_const", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
